// File: rtl/alm_err_sweep_monitor.sv
// -----------------------------------------------------------------------------
// alm_err_sweep_monitor
//
// Purpose
//   On-chip error characterisation for an approximate multiplier. The block
//   drives every DWIDTH x DWIDTH operand pair into a multiplier under test, A as
//   the outer loop. It captures the product DUT_LAT cycles later and compares it
//   with the exact product computed here. It accumulates error-distance
//   statistics so the host can derive NMED:
//     NMED = o_err_sum / (2^(2*DWIDTH) * (2^DWIDTH-1)^2)
//
// Parameters
//   DWIDTH     operand width; one sweep issues N = 2^(2*DWIDTH) pairs
//   DUT_LAT    cycles from an o_a/o_b change to the matching i_z (0..7)
//   ACC_WIDTH  width of the saturating error-sum accumulator
//
// Ports
//   i_clk      clock, rising edge
//   i_rst_n    asynchronous active-low reset
//   i_start    start request, only honoured while idle
//   o_busy     high while pairs are issued or in flight
//   o_done     one-cycle pulse; statistics are final while it is high
//   o_a, o_b   operands presented to the multiplier under test
//   i_z        product from the multiplier under test
//   o_err_sum  saturating sum of |exact - i_z|
//   o_err_max  largest single |exact - i_z|
//   o_err_cnt  number of pairs with i_z != exact
//   o_worst_a  A operand of the first pair that reached o_err_max
//   o_worst_b  B operand of the first pair that reached o_err_max
// -----------------------------------------------------------------------------
module alm_err_sweep_monitor #(
  parameter int DWIDTH    = 8,
  parameter int DUT_LAT   = 0,
  parameter int ACC_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [DWIDTH-1:0]     o_a,
  output logic [DWIDTH-1:0]     o_b,
  input  logic [2*DWIDTH-1:0]   i_z,
  output logic [ACC_WIDTH-1:0]  o_err_sum,
  output logic [2*DWIDTH-1:0]   o_err_max,
  output logic [2*DWIDTH:0]     o_err_cnt,
  output logic [DWIDTH-1:0]     o_worst_a,
  output logic [DWIDTH-1:0]     o_worst_b
);

  localparam int PW = 2 * DWIDTH;
  // Sum width wide enough that a single addition can never wrap before the
  // clamp decision, even if ACC_WIDTH is narrower than one error value.
  localparam int SW = ((ACC_WIDTH > PW) ? ACC_WIDTH : PW) + 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SWEEP = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // Last drain cycle index; unused when DUT_LAT is 0 because DRAIN is skipped.
  localparam logic [2:0] DRAIN_LAST = 3'((DUT_LAT > 0) ? DUT_LAT - 1 : 0);

  logic [1:0]    state;
  logic [PW-1:0] cnt;        // pair index; its halves are the operands
  logic [2:0]    drain_cnt;

  logic          start_ok;
  logic          issue_vld;
  logic          last_pair;

  // Capture side: the pair whose product is on i_z in this cycle.
  logic          cap_vld;
  logic [PW-1:0] cap_exact;
  logic [DWIDTH-1:0] cap_a;
  logic [DWIDTH-1:0] cap_b;

  logic [PW-1:0] exact_now;
  logic [PW-1:0] err;
  logic [SW-1:0] sum_ext;
  logic [ACC_WIDTH-1:0] sum_next;

  // The operands are the counter itself, so they hold all-ones through DRAIN
  // and DONE and read 0 whenever the block is idle.
  assign o_a       = cnt[PW-1:DWIDTH];
  assign o_b       = cnt[DWIDTH-1:0];
  assign o_busy    = (state == ST_SWEEP) || (state == ST_DRAIN);
  assign o_done    = (state == ST_DONE);

  assign start_ok  = (state == ST_IDLE) && i_start;
  assign issue_vld = (state == ST_SWEEP);
  assign last_pair = &cnt;
  assign exact_now = PW'(o_a) * PW'(o_b);

  // ---------------------------------------------------------------------------
  // Sequencer
  // ---------------------------------------------------------------------------
  // NOTE: state registers use non-blocking assignments so every always_ff
  // samples the pre-edge values of its neighbours regardless of block order.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      drain_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_start) begin
            state <= ST_SWEEP;
            cnt   <= '0;
          end
        end
        ST_SWEEP: begin
          if (last_pair) begin
            // A combinational multiplier has nothing in flight, so there is
            // no drain phase.
            state     <= (DUT_LAT == 0) ? ST_DONE : ST_DRAIN;
            drain_cnt <= '0;
          end else begin
            cnt <= cnt + PW'(1);
          end
        end
        ST_DRAIN: begin
          if (drain_cnt == DRAIN_LAST) begin
            state <= ST_DONE;
          end else begin
            drain_cnt <= drain_cnt + 3'd1;
          end
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Valid / exact-product shift line aligning reference with i_z
  // ---------------------------------------------------------------------------
  generate
    if (DUT_LAT == 0) begin : g_no_pipe
      assign cap_vld   = issue_vld;
      assign cap_exact = exact_now;
      assign cap_a     = o_a;
      assign cap_b     = o_b;
    end else begin : g_pipe
      logic              pipe_vld   [DUT_LAT];
      logic [PW-1:0]     pipe_exact [DUT_LAT];
      logic [DWIDTH-1:0] pipe_a     [DUT_LAT];
      logic [DWIDTH-1:0] pipe_b     [DUT_LAT];

      // NOTE: this small array is reset on purpose so a reset mid-sweep
      // cannot leave stale valid entries that would be captured later; large
      // data memories would normally be left unreset and qualified instead.
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          for (int i = 0; i < DUT_LAT; i++) begin
            pipe_vld[i]   <= 1'b0;
            pipe_exact[i] <= '0;
            pipe_a[i]     <= '0;
            pipe_b[i]     <= '0;
          end
        end else begin
          pipe_vld[0]   <= issue_vld;
          pipe_exact[0] <= exact_now;
          pipe_a[0]     <= o_a;
          pipe_b[0]     <= o_b;
          for (int i = 1; i < DUT_LAT; i++) begin
            pipe_vld[i]   <= pipe_vld[i-1];
            pipe_exact[i] <= pipe_exact[i-1];
            pipe_a[i]     <= pipe_a[i-1];
            pipe_b[i]     <= pipe_b[i-1];
          end
        end
      end

      assign cap_vld   = pipe_vld[DUT_LAT-1];
      assign cap_exact = pipe_exact[DUT_LAT-1];
      assign cap_a     = pipe_a[DUT_LAT-1];
      assign cap_b     = pipe_b[DUT_LAT-1];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Error distance and saturating sum
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here gets a value before any branch, so no
  // path can leave one unassigned and infer a latch.
  always_comb begin
    err     = '0;
    sum_ext = '0;
    if (cap_exact >= i_z) begin
      err = cap_exact - i_z;
    end else begin
      err = i_z - cap_exact;
    end
    sum_ext  = SW'(o_err_sum) + SW'(err);
    sum_next = (|sum_ext[SW-1:ACC_WIDTH]) ? '1 : sum_ext[ACC_WIDTH-1:0];
  end

  // ---------------------------------------------------------------------------
  // Statistics
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_err_sum <= '0;
      o_err_max <= '0;
      o_err_cnt <= '0;
      o_worst_a <= '0;
      o_worst_b <= '0;
    end else if (start_ok) begin
      o_err_sum <= '0;
      o_err_max <= '0;
      o_err_cnt <= '0;
      o_worst_a <= '0;
      o_worst_b <= '0;
    end else if (cap_vld) begin
      o_err_sum <= sum_next;
      if (err != '0) begin
        o_err_cnt <= o_err_cnt + (PW+1)'(1);
      end
      // Strict comparison: on a tie the earlier pair stays the worst case.
      if (err > o_err_max) begin
        o_err_max <= err;
        o_worst_a <= cap_a;
        o_worst_b <= cap_b;
      end
    end
  end

endmodule

// File: tb/tb_alm_err_sweep_monitor.sv
// -----------------------------------------------------------------------------
// tb_alm_err_sweep_monitor
//
// Two monitors with DWIDTH=4 (256-pair sweeps): one with a combinational
// multiplier stub (DUT_LAT=0, 32-bit sum) and one with a registered stub
// (DUT_LAT=2, 12-bit sum so saturation is reachable). Expected statistics come
// from a plain nested-loop model over all operand pairs.
// -----------------------------------------------------------------------------
module tb_alm_err_sweep_monitor;

  localparam int DW   = 4;
  localparam int PW   = 2 * DW;
  localparam int N    = 1 << PW;
  localparam int AMAX = (1 << DW) - 1;
  localparam int ACC0 = 32;
  localparam int ACC2 = 12;
  localparam int BUDGET = 2000;

  // Multiplier stub behaviours.
  localparam int M_EXACT = 0;
  localparam int M_PLUS1 = 1;
  localparam int M_ZERO  = 2;
  localparam int M_RAND  = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  int delta [16][16];
  int mode0;
  int mode2;
  int z2_regs;

  // Instance with a combinational multiplier
  logic              start0, busy0, done0;
  logic [DW-1:0]     a0, b0, wa0, wb0;
  logic [PW-1:0]     z0, max0;
  logic [ACC0-1:0]   sum0;
  logic [PW:0]       cnt0;

  // Instance with a registered multiplier
  logic              start2, busy2, done2;
  logic [DW-1:0]     a2, b2, wa2, wb2;
  logic [PW-1:0]     z2, z2_comb, r1, r2, r3, max2;
  logic [ACC2-1:0]   sum2;
  logic [PW:0]       cnt2;

  function automatic logic [PW-1:0] fake_mul(input int mode, input int a,
                                              input int b, input int d);
    int p;
    case (mode)
      M_EXACT: p = a * b;
      M_PLUS1: p = a * b + 1;
      M_ZERO:  p = 0;
      default: p = a * b + d;
    endcase
    if (p < 0) p = 0;
    if (p > N - 1) p = N - 1;
    return PW'(p);
  endfunction

  assign z0      = fake_mul(mode0, int'(a0), int'(b0), delta[a0][b0]);
  assign z2_comb = fake_mul(mode2, int'(a2), int'(b2), delta[a2][b2]);

  always_ff @(posedge clk) begin
    r1 <= z2_comb;
    r2 <= r1;
    r3 <= r2;
  end

  assign z2 = (z2_regs == 1) ? r1 : (z2_regs == 2) ? r2 : r3;

  alm_err_sweep_monitor #(.DWIDTH(DW), .DUT_LAT(0), .ACC_WIDTH(ACC0)) u_dut_l0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start0),
    .o_busy(busy0), .o_done(done0), .o_a(a0), .o_b(b0), .i_z(z0),
    .o_err_sum(sum0), .o_err_max(max0), .o_err_cnt(cnt0),
    .o_worst_a(wa0), .o_worst_b(wb0)
  );

  alm_err_sweep_monitor #(.DWIDTH(DW), .DUT_LAT(2), .ACC_WIDTH(ACC2)) u_dut_l2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start2),
    .o_busy(busy2), .o_done(done2), .o_a(a2), .o_b(b2), .i_z(z2),
    .o_err_sum(sum2), .o_err_max(max2), .o_err_cnt(cnt2),
    .o_worst_a(wa2), .o_worst_b(wb2)
  );

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Reference: walk all pairs in sweep order and apply the statistic rules.
  task automatic model(input int mode, input int acc_w,
                       output longint e_sum, output longint e_cnt,
                       output longint e_max, output longint e_wa,
                       output longint e_wb);
    longint cap;
    longint ex, z, err;
    cap = (longint'(1) << acc_w) - 1;
    e_sum = 0; e_cnt = 0; e_max = 0; e_wa = 0; e_wb = 0;
    for (int a = 0; a <= AMAX; a++) begin
      for (int b = 0; b <= AMAX; b++) begin
        ex  = a * b;
        z   = longint'(fake_mul(mode, a, b, delta[a][b]));
        err = (ex > z) ? ex - z : z - ex;
        e_sum += err;
        if (e_sum > cap) e_sum = cap;
        if (err != 0) e_cnt++;
        if (err > e_max) begin
          e_max = err; e_wa = a; e_wb = b;
        end
      end
    end
  endtask

  task automatic check_stats(input string tag, input int inst, input int mode);
    longint e_sum, e_cnt, e_max, e_wa, e_wb;
    model(mode, (inst == 0) ? ACC0 : ACC2, e_sum, e_cnt, e_max, e_wa, e_wb);
    if (inst == 0) begin
      check({tag, "_sum"}, sum0, e_sum);
      check({tag, "_cnt"}, cnt0, e_cnt);
      check({tag, "_max"}, max0, e_max);
      check({tag, "_worst_a"}, wa0, e_wa);
      check({tag, "_worst_b"}, wb0, e_wb);
    end else begin
      check({tag, "_sum"}, sum2, e_sum);
      check({tag, "_cnt"}, cnt2, e_cnt);
      check({tag, "_max"}, max2, e_max);
      check({tag, "_worst_a"}, wa2, e_wa);
      check({tag, "_worst_b"}, wb2, e_wb);
    end
  endtask

  task automatic set_start(input int inst, input logic v);
    if (inst == 0) start0 = v;
    else start2 = v;
  endtask

  // Starts one sweep and waits for o_done. cycles = negedges from the start
  // edge up to and including the o_done cycle. Optional extra start pulses
  // mid-sweep; optional start held high through the end.
  task automatic run(input string tag, input int inst, input bit pulses,
                     input bit hold, output int cycles, output int n_done);
    bit seen;
    logic d, bz;
    seen = 1'b0;
    cycles = 0;
    n_done = 0;
    @(negedge clk);
    set_start(inst, 1'b1);
    while (cycles < BUDGET && !seen) begin
      @(negedge clk);
      cycles++;
      set_start(inst, hold || (pulses && (cycles == 10 || cycles == 100)));
      d  = (inst == 0) ? done0 : done2;
      bz = (inst == 0) ? busy0 : busy2;
      if (cycles == 5) check({tag, "_busy_mid"}, bz, 1);
      if (d) begin
        seen = 1'b1;
        n_done++;
      end
    end
    check({tag, "_done_seen"}, seen, 1);
  endtask

  int cyc, nd;
  logic [DW-1:0] ones;

  initial begin
    ones    = '1;
    rst_n   = 1'b0;
    start0  = 1'b0;
    start2  = 1'b0;
    mode0   = M_EXACT;
    mode2   = M_EXACT;
    z2_regs = 2;
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        delta[a][b] = 0;

    repeat (3) @(negedge clk);
    check("rst_busy0", busy0, 0);
    check("rst_done0", done0, 0);
    check("rst_ab0", {a0, b0}, 0);
    check("rst_stats0", {sum0, max0, cnt0, wa0, wb0}, 0);
    check("rst_busy2", busy2, 0);
    check("rst_stats2", {sum2, max2, cnt2, wa2, wb2}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Exact combinational multiplier: latency N+1, zero statistics.
    mode0 = M_EXACT;
    run("exact0", 0, 1'b0, 1'b0, cyc, nd);
    check("exact0_latency", cyc, N + 1);
    check("exact0_busy_at_done", busy0, 0);
    check("exact0_a_hold", a0, ones);
    check("exact0_b_hold", b0, ones);
    check_stats("exact0", 0, M_EXACT);
    @(negedge clk);
    check("exact0_done_pulse", done0, 0);
    check("exact0_idle_a", a0, 0);
    check("exact0_stats_hold", sum0, 0);

    // Off-by-one and all-zero multipliers.
    mode0 = M_PLUS1;
    run("plus1", 0, 1'b0, 1'b0, cyc, nd);
    check_stats("plus1", 0, M_PLUS1);
    check("plus1_sum_direct", sum0, N);
    mode0 = M_ZERO;
    run("zero0", 0, 1'b0, 1'b0, cyc, nd);
    check_stats("zero0", 0, M_ZERO);

    // Registered exact multiplier on the latency-2 instance.
    mode2 = M_EXACT;
    z2_regs = 2;
    run("exact2", 2, 1'b0, 1'b0, cyc, nd);
    check("exact2_latency", cyc, N + 3);
    check_stats("exact2", 2, M_EXACT);

    // Saturating accumulator on the 12-bit instance.
    mode2 = M_ZERO;
    run("sat2", 2, 1'b0, 1'b0, cyc, nd);
    check_stats("sat2", 2, M_ZERO);

    // Latency misalignment must show errors.
    mode2 = M_EXACT;
    z2_regs = 1;
    run("mis1", 2, 1'b0, 1'b0, cyc, nd);
    check("mis1_cnt_nonzero", cnt2 != 0, 1);
    z2_regs = 3;
    run("mis3", 2, 1'b0, 1'b0, cyc, nd);
    check("mis3_cnt_nonzero", cnt2 != 0, 1);
    z2_regs = 2;

    // Randomised error tables on both instances.
    for (int r = 0; r < 4; r++) begin
      for (int a = 0; a < 16; a++)
        for (int b = 0; b < 16; b++)
          delta[a][b] = ($urandom_range(0, 1) == 0) ? 0
                        : int'($urandom_range(0, 40)) - 20;
      mode0 = M_RAND;
      run($sformatf("rand0_%0d", r), 0, 1'b0, 1'b0, cyc, nd);
      check_stats($sformatf("rand0_%0d", r), 0, M_RAND);
      mode2 = M_RAND;
      run($sformatf("rand2_%0d", r), 2, 1'b0, 1'b0, cyc, nd);
      check_stats($sformatf("rand2_%0d", r), 2, M_RAND);
    end

    // Start pulses mid-sweep are ignored: one o_done, same statistics.
    mode0 = M_RAND;
    run("pulses", 0, 1'b1, 1'b0, cyc, nd);
    check("pulses_latency", cyc, N + 1);
    check_stats("pulses", 0, M_RAND);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (done0) nd++;
    end
    check("pulses_single_done", nd, 1);

    // Start held high: DONE -> IDLE for a cycle, then the next sweep starts.
    mode0 = M_EXACT;
    run("hold", 0, 1'b0, 1'b1, cyc, nd);
    @(negedge clk);
    check("hold_idle_busy", busy0, 0);
    check("hold_idle_a", a0, 0);
    @(negedge clk);
    start0 = 1'b0;
    check("hold_restart_busy", busy0, 1);
    cyc = 0;
    while (cyc < BUDGET && !done0) begin
      @(negedge clk);
      cyc++;
    end
    check("hold_second_done", done0, 1);
    check_stats("hold", 0, M_EXACT);

    // Reset in the middle of a sweep aborts and zeroes everything.
    mode0 = M_RAND;
    @(negedge clk);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    repeat (100) @(negedge clk);
    check("abort_busy_before", busy0, 1);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_busy", busy0, 0);
    check("abort_outputs", {done0, a0, b0, sum0, max0, cnt0, wa0, wb0}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_after_release", {busy0, sum0, cnt0}, 0);
    mode0 = M_EXACT;
    run("after_abort", 0, 1'b0, 1'b0, cyc, nd);
    check("after_abort_latency", cyc, N + 1);
    check_stats("after_abort", 0, M_EXACT);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
